vga_sync_generator: RTL and testbench

//  - Raster timing source for the VGA display path. Runs on the 25 MHz pixel clock from the PLL.
//  - Counts pixels and lines. Drives pixel coordinates, an active-video flag and line/frame strobes
//    to the picture generator, which turns them into RGB.
//  - Drives vga_h_sync / vga_v_sync and a blanking flag. These pass through a delay line, so

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_delay_line.sv | 46 ++++
 rtl/vga_sync_generator.sv | 137 +++++++++++++
 tb/tb_vga_sync_generator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants, sync/blank bundle type and width helper.
// Latency: none, constants and pure functions only.
// Backpressure: none.
//
// Ports: none (package). Used by the sync generator and by the picture generator
// for its coordinate ranges.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Levels that travel down the sync/blank delay line together.
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic blank_n;
    } vga_sync_t;

    // Counter width able to hold h_total-1 and v_total-1.
    function automatic int vga_coord_width(input int h_total, input int v_total);
        int m;
        m = (h_total > v_total) ? h_total : v_total;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth registered shift register with synchronous reset; DEPTH=0 is a wire.
// Latency: DEPTH clk cycles.
// Backpressure: none, shifts every cycle.
//
// Ports:
//  clk    in  1      clock
//  reset  in  1      synchronous active-high; loads every stage with RESET_VAL
//  din    in  WIDTH  data entering stage 0
//  dout   out WIDTH  data leaving the last stage
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset};
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_generator.sv
// Free-running VGA raster timing: pixel/line counters, coordinate decodes, frame counter, delayed sync/blank.
// Latency: pix_x/pix_y/active/strobes 1 cycle after counter state; sync/blank 1+PIPE_DELAY cycles.
// Backpressure: none, never stalls.
//
// Ports:
//  clk          in  1   pixel clock
//  reset        in  1   synchronous active-high; aborts the frame, clears counters and delay stages
//  pix_x        out CW  horizontal position
//  pix_y        out CW  vertical position
//  active       out 1   inside the visible area
//  line_start   out 1   strobe at pix_x==0
//  frame_start  out 1   strobe at pix_x==0, pix_y==0
//  frame_cnt    out 8   frame counter, bumps with frame_start
//  vga_h_sync   out 1   horizontal sync, delayed to match the colour pipeline
//  vga_v_sync   out 1   vertical sync, delayed to match the colour pipeline
//  vga_blank_n  out 1   delayed copy of active
module vga_sync_generator #(
    parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int   H_FP       = vga_pkg::H_FP,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BP       = vga_pkg::H_BP,
    parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int   V_FP       = vga_pkg::V_FP,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BP       = vga_pkg::V_BP,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   PIPE_DELAY = 2,
    parameter int   CW         = 10
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic          vga_blank_n
);

    import vga_pkg::*;

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(FRAME_LINES - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Idle level of the sync bundle: both syncs de-asserted, picture blanked.
    localparam vga_sync_t SYNC_IDLE = '{h_sync: ~H_SYNC_POL, v_sync: ~V_SYNC_POL, blank_n: 1'b0};

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          hc_wrap;
    logic          vc_wrap;
    logic          active_dec;
    logic          line_dec;
    logic          frame_dec;
    vga_sync_t     sync_dec;
    vga_sync_t     sync_q;
    vga_sync_t     sync_out;

    always_comb begin
        hc_wrap    = (hc == H_LAST);
        vc_wrap    = (vc == V_LAST);
        active_dec = (hc < H_VIS) && (vc < V_VIS);
        line_dec   = (hc == '0);
        frame_dec  = line_dec && (vc == '0);

        sync_dec = SYNC_IDLE;
        if ((hc >= HS_FIRST) && (hc <= HS_LAST)) begin
            sync_dec.h_sync = H_SYNC_POL;
        end
        // V-sync spans whole lines, so it depends on vc alone.
        if ((vc >= VS_FIRST) && (vc <= VS_LAST)) begin
            sync_dec.v_sync = V_SYNC_POL;
        end
        sync_dec.blank_n = active_dec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
            sync_q      <= SYNC_IDLE;
        end else begin
            hc <= hc_wrap ? '0 : hc + 1'b1;
            if (hc_wrap) begin
                vc <= vc_wrap ? '0 : vc + 1'b1;
            end
            pix_x       <= hc;
            pix_y       <= vc;
            active      <= active_dec;
            line_start  <= line_dec;
            frame_start <= frame_dec;
            // Bumped on the same edge that registers frame_start, so the new
            // count is visible alongside the strobe.
            if (frame_dec) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            sync_q <= sync_dec;
        end
    end

    // sync_q is already aligned with pix_x; the delay line adds the colour
    // pipeline depth. Reset reloads every stage so no partial pulse survives.
    vga_delay_line #(
        .WIDTH     ($bits(vga_sync_t)),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .din   (sync_q),
        .dout  (sync_out)
    );

    assign vga_h_sync  = sync_out.h_sync;
    assign vga_v_sync  = sync_out.v_sync;
    assign vga_blank_n = sync_out.blank_n;

endmodule

// File: tb/tb_vga_sync_generator.sv
module tb_vga_sync_generator;
    import vga_pkg::*;

    localparam int S_CW = vga_coord_width(15, 8);

    logic clk;
    logic reset;

    logic [9:0] f_px, f_py;
    logic       f_act, f_ls, f_fs, f_hs, f_vs, f_bn;
    logic [7:0] f_fc;

    logic [S_CW-1:0] s0_px, s0_py, s2_px, s2_py, s5_px, s5_py;
    logic            s0_act, s0_ls, s0_fs, s0_hs, s0_vs, s0_bn;
    logic            s2_act, s2_ls, s2_fs, s2_hs, s2_vs, s2_bn;
    logic            s5_act, s5_ls, s5_fs, s5_hs, s5_vs, s5_bn;
    logic [7:0]      s0_fc, s2_fc, s5_fc;

    int total;
    int bad;
    int n;

    int ls_cnt, act_run, act_len, px655_n, hs0_n, hs_low, vs_low, fs_k, fs_cnt;
    int fs_n [3];
    int hs0_d [3];
    int bnr_d [3];
    int bnf_d [3];

    vga_sync_generator u_full (
        .clk(clk), .reset(reset), .pix_x(f_px), .pix_y(f_py), .active(f_act),
        .line_start(f_ls), .frame_start(f_fs), .frame_cnt(f_fc),
        .vga_h_sync(f_hs), .vga_v_sync(f_vs), .vga_blank_n(f_bn)
    );

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DELAY(0), .CW(S_CW)
    ) u_p0 (
        .clk(clk), .reset(reset), .pix_x(s0_px), .pix_y(s0_py), .active(s0_act),
        .line_start(s0_ls), .frame_start(s0_fs), .frame_cnt(s0_fc),
        .vga_h_sync(s0_hs), .vga_v_sync(s0_vs), .vga_blank_n(s0_bn)
    );

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DELAY(2), .CW(S_CW)
    ) u_p2 (
        .clk(clk), .reset(reset), .pix_x(s2_px), .pix_y(s2_py), .active(s2_act),
        .line_start(s2_ls), .frame_start(s2_fs), .frame_cnt(s2_fc),
        .vga_h_sync(s2_hs), .vga_v_sync(s2_vs), .vga_blank_n(s2_bn)
    );

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DELAY(5), .CW(S_CW)
    ) u_p5 (
        .clk(clk), .reset(reset), .pix_x(s5_px), .pix_y(s5_py), .active(s5_act),
        .line_start(s5_ls), .frame_start(s5_fs), .frame_cnt(s5_fc),
        .vga_h_sync(s5_hs), .vga_v_sync(s5_vs), .vga_blank_n(s5_bn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raster model: n counts edges since reset was released (0 = in reset).
    task automatic model_chk(input string nm, input int ha, input int hf, input int hs,
                             input int ht, input int va, input int vf, input int vs,
                             input int vt, input int d,
                             input logic [9:0] px, input logic [9:0] py,
                             input logic act, input logic ls, input logic fs,
                             input logic [7:0] fc, input logic hsy, input logic vsy,
                             input logic bn);
        int pos, x, y, q, qx, qy, efc;
        logic e_hs, e_vs, e_bn;
        x = 0; y = 0; efc = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0;
        if (n > 0) begin
            pos = n - 1;
            x   = pos % ht;
            y   = (pos / ht) % vt;
            efc = ((pos / (ht * vt)) + 1) % 256;
        end
        q = n - 1 - d;
        if (n > 0 && q >= 0) begin
            qx   = q % ht;
            qy   = (q / ht) % vt;
            e_hs = !(qx >= ha + hf && qx < ha + hf + hs);
            e_vs = !(qy >= va + vf && qy < va + vf + vs);
            e_bn = (qx < ha) && (qy < va);
        end
        chk({nm, "_px"}, px, x);
        chk({nm, "_py"}, py, y);
        chk({nm, "_act"}, act, (n > 0) && (x < ha) && (y < va));
        chk({nm, "_ls"}, ls, (n > 0) && (x == 0));
        chk({nm, "_fs"}, fs, (n > 0) && (x == 0) && (y == 0));
        chk({nm, "_fc"}, fc, efc);
        chk({nm, "_hs"}, hsy, e_hs);
        chk({nm, "_vs"}, vsy, e_vs);
        chk({nm, "_bn"}, bn, e_bn);
    endtask

    task automatic step();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else n++;
        model_chk("full", 640, 16, 96, 800, 480, 10, 2, 525, 2,
                  f_px, f_py, f_act, f_ls, f_fs, f_fc, f_hs, f_vs, f_bn);
        model_chk("p0", 8, 2, 3, 15, 4, 1, 2, 8, 0, {6'd0, s0_px}, {6'd0, s0_py},
                  s0_act, s0_ls, s0_fs, s0_fc, s0_hs, s0_vs, s0_bn);
        model_chk("p2", 8, 2, 3, 15, 4, 1, 2, 8, 2, {6'd0, s2_px}, {6'd0, s2_py},
                  s2_act, s2_ls, s2_fs, s2_fc, s2_hs, s2_vs, s2_bn);
        model_chk("p5", 8, 2, 3, 15, 4, 1, 2, 8, 5, {6'd0, s5_px}, {6'd0, s5_py},
                  s5_act, s5_ls, s5_fs, s5_fc, s5_hs, s5_vs, s5_bn);
    endtask

    task automatic upd_dly(input int i, input logic hsy, input logic bn);
        if (hsy === 1'b0 && hs0_d[i] < 0) hs0_d[i] = n;
        if (bn === 1'b1 && bnr_d[i] < 0) bnr_d[i] = n;
        if (bn === 1'b0 && bnr_d[i] >= 0 && bnf_d[i] < 0) bnf_d[i] = n;
    endtask

    task automatic track();
        if (n <= 800 && f_ls === 1'b1) ls_cnt++;
        if (n <= 800) begin
            if (f_act === 1'b1) act_run++;
            else if (act_run > 0 && act_len < 0) act_len = act_run;
        end
        if (f_px === 10'd655 && px655_n < 0) px655_n = n;
        if (f_hs === 1'b0 && hs0_n < 0) hs0_n = n;
        if (n <= 1000 && f_hs === 1'b0) hs_low++;
        if (n == 800) chk("px_end", f_px, 799);
        if (n == 801) chk("px_wrap", f_px, 0);
        if (n <= 120 && s2_vs === 1'b0) vs_low++;
        if (s2_fs === 1'b1 && fs_k < 3) begin
            fs_n[fs_k] = n;
            fs_k++;
        end
        if (n == 120) chk("py_last", s2_py, 7);
        if (n == 121) chk("py_wrap", s2_py, 0);
        if (n == 241) chk("fc_three", s2_fc, 3);
        upd_dly(0, s0_hs, s0_bn);
        upd_dly(1, s2_hs, s2_bn);
        upd_dly(2, s5_hs, s5_bn);
    endtask

    initial begin
        total = 0; bad = 0; n = 0;
        ls_cnt = 0; act_run = 0; act_len = -1; px655_n = -1; hs0_n = -1;
        hs_low = 0; vs_low = 0; fs_k = 0; fs_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            fs_n[i] = -1; hs0_d[i] = -1; bnr_d[i] = -1; bnf_d[i] = -1;
        end

        // Reset held for 5 edges.
        reset = 1'b1;
        repeat (5) begin
            step();
            chk("rst_px", f_px, 0);
            chk("rst_py", f_py, 0);
            chk("rst_hs", f_hs, 1);
            chk("rst_vs", f_vs, 1);
            chk("rst_bn", f_bn, 0);
        end
        reset = 1'b0;

        step();
        chk("first_fs", f_fs, 1);
        chk("first_fc", f_fc, 1);
        chk("first_act", f_act, 1);
        chk("first_ls", f_ls, 1);
        track();

        while (n < 1647) begin
            step();
            track();
        end

        chk("line_starts", ls_cnt, 1);
        chk("act_len", act_len, 640);
        chk("px655_at", px655_n, 656);
        chk("hs_after_655", hs0_n - px655_n, 3);
        chk("hs_low_len", hs_low, 96);
        chk("vs_low_len", vs_low, 30);
        chk("fs_gap1", fs_n[1] - fs_n[0], 120);
        chk("fs_gap2", fs_n[2] - fs_n[1], 120);
        chk("p0_hs_first", hs0_d[0], 11);
        chk("p2_hs_first", hs0_d[1], 13);
        chk("p5_hs_first", hs0_d[2], 16);
        chk("p0_bn_rise", bnr_d[0], 1);
        chk("p2_bn_rise", bnr_d[1], 3);
        chk("p5_bn_rise", bnr_d[2], 6);
        chk("p0_bn_fall", bnf_d[0], 9);
        chk("p2_bn_fall", bnf_d[1], 11);
        chk("p5_bn_fall", bnf_d[2], 14);

        // Land inside both syncs on p2 (x=12, y=5), then abort the frame.
        step();
        chk("pre_rst_px", s2_px, 12);
        chk("pre_rst_py", s2_py, 5);
        chk("pre_rst_hs", s2_hs, 0);
        chk("pre_rst_vs", s2_vs, 0);
        chk("pre_rst_p5_vs", s5_vs, 0);
        reset = 1'b1;
        step();
        chk("mid_rst_hs", s2_hs, 1);
        chk("mid_rst_vs", s2_vs, 1);
        chk("mid_rst_bn", s2_bn, 0);
        chk("mid_rst_px", s2_px, 0);
        chk("mid_rst_py", s2_py, 0);
        chk("mid_rst_p5_vs", s5_vs, 1);
        chk("mid_rst_full_px", f_px, 0);
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("restart_fs", f_fs, 1);
        chk("restart_fc", f_fc, 1);
        chk("restart_act", f_act, 1);
        chk("restart_p2_fs", s2_fs, 1);
        chk("restart_p2_fc", s2_fc, 1);

        // Long run to the 255 -> 0 frame counter wrap on the small rasters.
        while (n < 30599) begin
            step();
            if (n >= 30500 && s2_fs === 1'b1) fs_cnt++;
        end
        step();
        chk("wrap_pre_fc", s2_fc, 255);
        chk("wrap_pre_fs", s2_fs, 0);
        step();
        if (s2_fs === 1'b1) fs_cnt++;
        chk("wrap_fc", s2_fc, 0);
        chk("wrap_fs", s2_fs, 1);
        step();
        chk("wrap_post_fc", s2_fc, 0);
        chk("wrap_post_fs", s2_fs, 0);
        while (n < 30700) begin
            step();
            if (s2_fs === 1'b1) fs_cnt++;
        end
        chk("wrap_fs_count", fs_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
